// File: rtl/merge_pass_sched.sv
// merge_pass_sched: merge-phase scheduler for the ping/pong sorter.
// After the sort phase leaves sorted runs of INIT_RUN pairs in ping, this
// block issues one merge job per adjacent run pair, waits for each job to
// complete, then swaps source/destination and doubles the run length until
// a single run covers all N entries. At most one job is ever outstanding.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 9
`endif

module merge_pass_sched #(
  parameter int CNT_W    = `BANK_ADDR_WIDTH + 1,
  parameter int INIT_RUN = 16,
  parameter int PASS_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   total_in,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [CNT_W-1:0]   job_a_base,
  output logic [CNT_W:0]     job_a_len,
  output logic [CNT_W-1:0]   job_b_base,
  output logic [CNT_W:0]     job_b_len,
  output logic               job_src_sel,
  input  logic               job_done,
  output logic               busy,
  output logic               done,
  output logic               result_sel,
  output logic [PASS_W-1:0]  pass_count
);

  // N needs one bit more than an address; run length and base carry a
  // further bit so that doubling / advancing by two runs never wraps.
  localparam int NW = CNT_W + 1;
  localparam int RW = CNT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PASS_END,
    S_DONE
  } state_t;

  state_t            state, state_nxt;

  logic [NW-1:0]     n_q, n_nxt;
  logic [RW-1:0]     run_len, run_nxt;
  logic [RW-1:0]     base, base_nxt;
  logic              src_sel, src_nxt;
  logic [PASS_W-1:0] pass_q, pass_nxt;
  logic              result_q, result_nxt;

  logic [CNT_W-1:0]  a_base_q, b_base_q;
  logic [CNT_W:0]    a_len_q, b_len_q;
  logic              sel_q;

  logic [RW-1:0]     n_cur, n_ext, step, base_adv;
  logic [RW-1:0]     a_len_c, b_base_c, b_len_c;
  logic              unused_hi;

  // Length clamp: a run never extends past the end of the data set.
  function automatic logic [RW-1:0] min_len(input logic [RW-1:0] x,
                                            input logic [RW-1:0] y);
    return (x < y) ? x : y;
  endfunction

  // Derived quantities: two-run stride and the fields of the next job,
  // computed from the values the registers will hold next cycle.
  always_comb begin
    n_cur    = {1'b0, n_q};
    n_ext    = {1'b0, n_nxt};
    step     = {run_len[RW-2:0], 1'b0};
    base_adv = base + step;
    a_len_c  = min_len(run_nxt, n_ext - base_nxt);
    b_base_c = base_nxt + a_len_c;
    b_len_c  = (n_ext > b_base_c) ? min_len(run_nxt, n_ext - b_base_c) : '0;
  end

  // Upper bits that are provably zero whenever a job is loaded.
  assign unused_hi = ^{a_len_c[RW-1], b_base_c[RW-1:CNT_W],
                       b_len_c[RW-1], base_nxt[RW-1:CNT_W]};

  // Next-state and next-value logic for the pass/job sequencer.
  always_comb begin
    state_nxt  = state;
    n_nxt      = n_q;
    run_nxt    = run_len;
    base_nxt   = base;
    src_nxt    = src_sel;
    pass_nxt   = pass_q;
    result_nxt = result_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_nxt      = {1'b0, total_in};
          run_nxt    = RW'(INIT_RUN);
          base_nxt   = '0;
          src_nxt    = 1'b0;
          pass_nxt   = '0;
          result_nxt = 1'b0;
          // Sort phase alone already produced one covering run.
          state_nxt  = ({2'b00, total_in} <= RW'(INIT_RUN)) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (job_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (job_done) begin
          base_nxt  = base_adv;
          state_nxt = (base_adv >= n_cur) ? S_PASS_END : S_ISSUE;
        end
      end
      S_PASS_END: begin
        src_nxt   = ~src_sel;
        run_nxt   = step;
        pass_nxt  = pass_q + 1'b1;
        base_nxt  = '0;
        state_nxt = (step >= n_cur) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        result_nxt = src_sel;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Pass bookkeeping and job field registers; fields load on every cycle
  // headed for ISSUE, so they stay constant while a job is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      n_q      <= '0;
      run_len  <= '0;
      base     <= '0;
      src_sel  <= 1'b0;
      pass_q   <= '0;
      result_q <= 1'b0;
      a_base_q <= '0;
      a_len_q  <= '0;
      b_base_q <= '0;
      b_len_q  <= '0;
      sel_q    <= 1'b0;
    end else begin
      n_q      <= n_nxt;
      run_len  <= run_nxt;
      base     <= base_nxt;
      src_sel  <= src_nxt;
      pass_q   <= pass_nxt;
      result_q <= result_nxt;
      if (state_nxt == S_ISSUE) begin
        a_base_q <= base_nxt[CNT_W-1:0];
        a_len_q  <= a_len_c[CNT_W:0];
        b_base_q <= b_base_c[CNT_W-1:0];
        b_len_q  <= b_len_c[CNT_W:0];
        sel_q    <= src_nxt;
      end
    end
  end

  assign job_valid   = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign job_a_base  = a_base_q;
  assign job_a_len   = a_len_q;
  assign job_b_base  = b_base_q;
  assign job_b_len   = b_len_q;
  assign job_src_sel = sel_q;
  assign result_sel  = (state == S_DONE) ? src_sel : result_q;
  assign pass_count  = pass_q;

endmodule

// File: tb/tb_merge_pass_sched.sv
// tb_merge_pass_sched: directed, table-driven bench for merge_pass_sched.
module tb_merge_pass_sched;

  localparam int CW = 10;
  localparam int PW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] total_in;
  logic          job_valid;
  logic          job_ready;
  logic [CW-1:0] job_a_base;
  logic [CW:0]   job_a_len;
  logic [CW-1:0] job_b_base;
  logic [CW:0]   job_b_len;
  logic          job_src_sel;
  logic          job_done;
  logic          busy;
  logic          done;
  logic          result_sel;
  logic [PW-1:0] pass_count;

  merge_pass_sched #(.CNT_W(CW), .INIT_RUN(16), .PASS_W(PW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .total_in    (total_in),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_a_base  (job_a_base),
    .job_a_len   (job_a_len),
    .job_b_base  (job_b_base),
    .job_b_len   (job_b_len),
    .job_src_sel (job_src_sel),
    .job_done    (job_done),
    .busy        (busy),
    .done        (done),
    .result_sel  (result_sel),
    .pass_count  (pass_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int ab; int al; int bb; int bl; int src;
  } job_t;

  typedef struct packed {
    int n; int first; int cnt; int pass; int res; int stall; int glitch;
  } scen_t;

  job_t  jobs [11];
  scen_t scen [8];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_fields(input int idx);
    check($sformatf("job%0d_a_base", idx), 32'(job_a_base),  jobs[idx].ab);
    check($sformatf("job%0d_a_len", idx),  32'(job_a_len),   jobs[idx].al);
    check($sformatf("job%0d_b_base", idx), 32'(job_b_base),  jobs[idx].bb);
    check($sformatf("job%0d_b_len", idx),  32'(job_b_len),   jobs[idx].bl);
    check($sformatf("job%0d_src", idx),    32'(job_src_sel), jobs[idx].src);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_job_valid"},  32'(job_valid),   0);
    check({tag, "_busy"},       32'(busy),        0);
    check({tag, "_done"},       32'(done),        0);
    check({tag, "_a_base"},     32'(job_a_base),  0);
    check({tag, "_a_len"},      32'(job_a_len),   0);
    check({tag, "_b_base"},     32'(job_b_base),  0);
    check({tag, "_b_len"},      32'(job_b_len),   0);
    check({tag, "_src"},        32'(job_src_sel), 0);
    check({tag, "_result_sel"}, 32'(result_sel),  0);
    check({tag, "_pass_count"}, 32'(pass_count),  0);
  endtask

  task automatic start_run(input int n);
    @(negedge clock);
    start    = 1'b1;
    total_in = CW'(n);
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Wait for the next job, check its latency and fields, optionally stall
  // it or throw a spurious job_done at it, then accept it.
  task automatic expect_job(input int idx, input int exp_wait, input int stall, input bit glitch);
    int w;
    w = 0;
    while (!job_valid && !done && w < 50) begin
      @(negedge clock);
      w++;
    end
    check($sformatf("job%0d_valid", idx), 32'(job_valid), 1);
    if (!job_valid) return;
    check($sformatf("job%0d_latency", idx), w, exp_wait);
    check_fields(idx);
    if (glitch) begin
      job_done = 1'b1;
      @(negedge clock);
      job_done = 1'b0;
      check($sformatf("job%0d_spurious_done_valid", idx), 32'(job_valid), 1);
      check_fields(idx);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check($sformatf("job%0d_stall%0d_valid", idx, s), 32'(job_valid), 1);
      check_fields(idx);
    end
    job_ready = 1'b1;
    @(negedge clock);
    job_ready = 1'b0;
    check($sformatf("job%0d_valid_drop", idx), 32'(job_valid), 0);
    check($sformatf("job%0d_busy", idx), 32'(busy), 1);
  endtask

  // From the first WAIT cycle: job_done lands 3 cycles after acceptance.
  task automatic finish_job(input bit glitch);
    if (glitch) begin
      start    = 1'b1;
      total_in = CW'(40);
    end
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    job_done = 1'b1;
    @(negedge clock);
    job_done = 1'b0;
  endtask

  task automatic expect_done(input string tag, input int exp_wait, input int pass, input int res);
    int w;
    w = 0;
    while (!done && !job_valid && w < 50) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_done"},        32'(done),       1);
    check({tag, "_no_job"},      32'(job_valid),  0);
    check({tag, "_done_latency"}, w,              exp_wait);
    check({tag, "_pass_count"},  32'(pass_count), pass);
    check({tag, "_result_sel"},  32'(result_sel), res);
    check({tag, "_busy_in_done"}, 32'(busy),      1);
    @(negedge clock);
    check({tag, "_done_pulse"},  32'(done),       0);
    check({tag, "_busy_after"},  32'(busy),       0);
    check({tag, "_pass_held"},   32'(pass_count), pass);
    check({tag, "_result_held"}, 32'(result_sel), res);
  endtask

  task automatic run_scen(input int si);
    string tag;
    int    ew;
    tag = $sformatf("scen%0d_n%0d", si, scen[si].n);
    start_run(scen[si].n);
    for (int j = 0; j < scen[si].cnt; j++) begin
      int idx;
      idx = scen[si].first + j;
      ew  = (j == 0) ? 0 : ((jobs[idx].src != jobs[idx-1].src) ? 1 : 0);
      expect_job(idx, ew, (j == 0) ? scen[si].stall : 0, (j == 0) && (scen[si].glitch != 0));
      finish_job((j == 0) && (scen[si].glitch != 0));
    end
    expect_done(tag, (scen[si].cnt == 0) ? 0 : 1, scen[si].pass, scen[si].res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0]  = '{0, 16, 16, 16, 0};
    jobs[1]  = '{32, 16, 48, 16, 0};
    jobs[2]  = '{0, 32, 32, 32, 1};
    jobs[3]  = '{0, 16, 16, 16, 0};
    jobs[4]  = '{32, 8, 40, 0, 0};
    jobs[5]  = '{0, 32, 32, 8, 1};
    jobs[6]  = '{0, 16, 16, 1, 0};
    jobs[7]  = '{0, 16, 16, 16, 0};
    jobs[8]  = '{0, 16, 16, 16, 0};
    jobs[9]  = '{32, 16, 48, 0, 0};
    jobs[10] = '{0, 32, 32, 16, 1};

    //            n  first cnt pass res stall glitch
    scen[0] = '{64,  0,   3,  2,   0,  0,    0};
    scen[1] = '{40,  3,   3,  2,   0,  0,    0};
    scen[2] = '{16,  0,   0,  0,   0,  0,    0};
    scen[3] = '{0,   0,   0,  0,   0,  0,    0};
    scen[4] = '{64,  0,   3,  2,   0,  5,    0};
    scen[5] = '{64,  0,   3,  2,   0,  0,    1};
    scen[6] = '{17,  6,   1,  1,   1,  0,    0};
    scen[7] = '{48,  8,   3,  2,   0,  0,    0};

    reset     = 1'b1;
    start     = 1'b0;
    total_in  = '0;
    job_ready = 1'b0;
    job_done  = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("post_reset");

    for (int si = 0; si < 8; si++) run_scen(si);

    // Reset during WAIT of the second pass, then a fresh N=32 run.
    start_run(64);
    expect_job(0, 0, 0, 1'b0);
    finish_job(1'b0);
    expect_job(1, 0, 0, 1'b0);
    finish_job(1'b0);
    expect_job(2, 1, 0, 1'b0);
    check("midrun_pass_count", 32'(pass_count), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("midrun_reset");
    start_run(32);
    expect_job(7, 0, 0, 1'b0);
    finish_job(1'b0);
    expect_done("after_reset_n32", 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
